// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter -- register-file write-back arbiter.
//
// Merges two write-back sources onto the single register-file write port:
//   * ALU results have no backpressure and always win the port.
//   * Load results are buffered in a small FIFO and drained only in cycles
//     with no ALU write.
// Queued load results can be forwarded to a query port. The youngest
// matching entry is returned.
//
// Ports
//   clk, rst                   clock, asynchronous active-high reset
//   alu_valid/alu_rd/alu_data  ALU result; rd = 0 is discarded
//   mem_valid/mem_ready        load handshake; mem_ready is (count < DEPTH)
//   mem_rd/mem_data            load result; rd = 0 is accepted and dropped
//   reg_write_en/write_addr/
//   write_data                 registered register-file write port
//   fifo_count                 number of queued load results
//   q_addr                     forwarding query register index
//   fwd_hit/fwd_data           forwarding result (combinational)
// -----------------------------------------------------------------------------
module wb_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_rd,
  input  logic [31:0]              alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [4:0]               mem_rd,
  input  logic [31:0]              mem_data,
  output logic                     reg_write_en,
  output logic [4:0]               write_addr,
  output logic [31:0]              write_data,
  output logic [$clog2(DEPTH):0]   fifo_count,
  input  logic [4:0]               q_addr,
  output logic                     fwd_hit,
  output logic [31:0]              fwd_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // FIFO storage. It has no reset: liveness is decided by count_reg alone.
  logic [4:0]        rd_mem   [DEPTH];
  logic [31:0]       data_mem [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;

  logic              reg_write_en_reg;
  logic [4:0]        write_addr_reg;
  logic [31:0]       write_data_reg;

  logic              alu_wr;
  logic              enq;
  logic              deq;

  // mem_ready comes from state only, so there is no input-to-output path.
  assign mem_ready  = (count_reg < CNT_W'(DEPTH));
  assign fifo_count = count_reg;

  assign alu_wr = alu_valid && (alu_rd != 5'd0);
  // A load to x0 still completes its handshake but is never stored.
  assign enq    = mem_valid && mem_ready && (mem_rd != 5'd0);
  assign deq    = !alu_wr && (count_reg != '0);

  assign reg_write_en = reg_write_en_reg;
  assign write_addr   = write_addr_reg;
  assign write_data   = write_data_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      reg_write_en_reg <= 1'b0;
      write_addr_reg   <= 5'd0;
      write_data_reg   <= 32'd0;
    end else begin
      if (enq) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (deq) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);

      case ({enq, deq})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase

      reg_write_en_reg <= alu_wr || deq;
      if (alu_wr) begin
        write_addr_reg <= alu_rd;
        write_data_reg <= alu_data;
      end else if (deq) begin
        write_addr_reg <= rd_mem[rd_ptr_reg];
        write_data_reg <= data_mem[rd_ptr_reg];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      rd_mem[wr_ptr_reg]   <= mem_rd;
      data_mem[wr_ptr_reg] <= mem_data;
    end
  end

  // Forwarding. Each slot's age is its distance from the read pointer. A slot
  // is live when its age is below the count, and larger ages are younger.
  // The entry being enqueued is not in storage yet, so the search cannot see
  // it. The head stays live until the dequeue edge.
  logic [PTR_W-1:0] slot_age [DEPTH];
  logic [DEPTH-1:0] slot_match;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign slot_age[gi]   = PTR_W'(gi) - rd_ptr_reg;
      assign slot_match[gi] = ({1'b0, slot_age[gi]} < count_reg) &&
                              (rd_mem[gi] == q_addr) && (q_addr != 5'd0);
    end
  endgenerate

  logic [PTR_W-1:0] best_age;

  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = 32'd0;
    best_age = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_match[i] && (!fwd_hit || (slot_age[i] > best_age))) begin
        fwd_hit  = 1'b1;
        best_age = slot_age[i];
        fwd_data = data_mem[i];
      end
    end
  end

endmodule
